// File: rtl/video_pkg.sv
// Shared raster definitions for the 720p display path: timing defaults, screen
// size and coordinate width used by the timing generator and the renderers.
package video_pkg;

  localparam int COORD_W  = 16;
  localparam int FCOUNT_W = 16;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  localparam int H_TOTAL_720P = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
  localparam int V_TOTAL_720P = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

  localparam int SCREEN_W = H_ACTIVE_720P;
  localparam int SCREEN_H = V_ACTIVE_720P;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  // True when lo <= cnt < lo+len.
  function automatic logic in_window(input logic [COORD_W-1:0] cnt, input int lo, input int len);
    return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register of configurable depth; DEPTH=0 is a straight wire.
// Used to realign de/syncs (and later colour) with downstream pipelines.
module sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{i_clk, i_rst_n, i_enable};
    assign o_data      = i_data;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d = stage_q;
      if (i_enable) begin
        stage_d[0] = i_data;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end
    end

    // NOTE: every stage is reset (not just the first) so the delayed syncs
    // never show a spurious active pulse while the line refills.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign o_data = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, one coherent output register stage and
// a delay line that realigns de/syncs with the downstream pixel pipeline.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_720P,
  parameter int   H_FP       = H_FP_720P,
  parameter int   H_SYNC     = H_SYNC_720P,
  parameter int   H_BP       = H_BP_720P,
  parameter int   V_ACTIVE   = V_ACTIVE_720P,
  parameter int   V_FP       = V_FP_720P,
  parameter int   V_SYNC     = V_SYNC_720P,
  parameter int   V_BP       = V_BP_720P,
  parameter logic SYNC_POL   = 1'b1,
  parameter int   PIPE_DELAY = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  output logic [COORD_W-1:0]  o_x,
  output logic [COORD_W-1:0]  o_y,
  output logic                o_de,
  output logic                o_h_sync,
  output logic                o_v_sync,
  output logic                o_frame_start,
  output logic [FCOUNT_W-1:0] o_frame_count,
  output logic                o_de_d,
  output logic                o_h_sync_d,
  output logic                o_v_sync_d
);

  localparam int    H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int    V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam sync_t SYNC_IDLE = '{de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

  logic [COORD_W-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [FCOUNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic                de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [FCOUNT_W-1:0] fcount_q, fcount_d;

  logic h_last, v_last;
  assign h_last = (h_cnt_q == COORD_W'(H_TOTAL - 1));
  assign v_last = (v_cnt_q == COORD_W'(V_TOTAL - 1));

  // NOTE: every signal gets a hold default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (i_enable) begin
      if (h_last) begin
        h_cnt_d = '0;
        if (v_last) begin
          v_cnt_d     = '0;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // All outputs sample the same counter value, so they stay mutually coherent.
  // The frame count lags its internal counter by one clock to land with frame_start.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    de_d     = de_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    fcount_d = fcount_q;
    fs_d     = 1'b0;
    if (i_enable) begin
      x_d      = h_cnt_q;
      y_d      = v_cnt_q;
      de_d     = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
      hs_d     = in_window(h_cnt_q, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
      vs_d     = in_window(v_cnt_q, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
      fs_d     = (h_cnt_q == '0) && (v_cnt_q == '0);
      fcount_d = frame_cnt_q;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      de_q        <= 1'b0;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      fs_q        <= 1'b0;
      fcount_q    <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
      fcount_q    <= fcount_d;
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_de          = de_q;
  assign o_h_sync      = hs_q;
  assign o_v_sync      = vs_q;
  assign o_frame_start = fs_q;
  assign o_frame_count = fcount_q;

  sync_t sync_now, sync_dly;
  assign sync_now = '{de: de_q, hs: hs_q, vs: vs_q};

  sync_delay_line #(
    .WIDTH     ($bits(sync_t)),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (i_enable),
    .i_data   (sync_now),
    .o_data   (sync_dly)
  );

  assign o_de_d     = sync_dly.de;
  assign o_h_sync_d = sync_dly.hs;
  assign o_v_sync_d = sync_dly.vs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: line-level checks on the 720p build, frame-level, enable-gap,
// reset and polarity checks on two reduced-timing builds (15x8 raster).
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, rst_s_n, en_s;

  // 720p build, PIPE_DELAY=2
  logic [15:0] m_x, m_y, m_fc;
  logic        m_de, m_hs, m_vs, m_fs, m_de_d, m_hs_d, m_vs_d;
  // small build, SYNC_POL=1, PIPE_DELAY=0
  logic [15:0] s_x, s_y, s_fc;
  logic        s_de, s_hs, s_vs, s_fs, s_de_d, s_hs_d, s_vs_d;
  // small build, SYNC_POL=0, PIPE_DELAY=2
  logic [15:0] n_x, n_y, n_fc;
  logic        n_de, n_hs, n_vs, n_fs, n_de_d, n_hs_d, n_vs_d;

  video_timing_gen u_main (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .o_x(m_x), .o_y(m_y), .o_de(m_de), .o_h_sync(m_hs), .o_v_sync(m_vs),
    .o_frame_start(m_fs), .o_frame_count(m_fc),
    .o_de_d(m_de_d), .o_h_sync_d(m_hs_d), .o_v_sync_d(m_vs_d)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .PIPE_DELAY(0)
  ) u_small (
    .i_clk(clk), .i_rst_n(rst_s_n), .i_enable(en_s),
    .o_x(s_x), .o_y(s_y), .o_de(s_de), .o_h_sync(s_hs), .o_v_sync(s_vs),
    .o_frame_start(s_fs), .o_frame_count(s_fc),
    .o_de_d(s_de_d), .o_h_sync_d(s_hs_d), .o_v_sync_d(s_vs_d)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .PIPE_DELAY(2)
  ) u_neg (
    .i_clk(clk), .i_rst_n(rst_s_n), .i_enable(en_s),
    .o_x(n_x), .o_y(n_y), .o_de(n_de), .o_h_sync(n_hs), .o_v_sync(n_vs),
    .o_frame_start(n_fs), .o_frame_count(n_fc),
    .o_de_d(n_de_d), .o_h_sync_d(n_hs_d), .o_v_sync_d(n_vs_d)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model of the small raster: position, frame count and the
  // {de, hs active, vs active} history feeding the 2-deep delay line.
  int         ex, ey, frames, s_errs, n_errs;
  logic [2:0] p_out, p_s1, p_s2;

  task automatic s_model_step();
    step(1);
    p_s2 = p_s1;
    p_s1 = p_out;
    if (ex == 14) begin
      ex = 0;
      if (ey == 7) begin ey = 0; frames++; end
      else ey++;
    end else begin
      ex++;
    end
    p_out = {(ex < 8) && (ey < 4), (ex >= 10) && (ex < 13), (ey >= 5) && (ey < 7)};
    if (s_x !== 16'(ex) || s_y !== 16'(ey) || s_fs !== ((ex == 0) && (ey == 0)) ||
        s_de !== p_out[2] || s_hs !== p_out[1] || s_vs !== p_out[0] ||
        s_fc !== 16'(frames) || s_de_d !== p_out[2] || s_hs_d !== p_out[1] ||
        s_vs_d !== p_out[0])
      s_errs++;
    if (n_hs !== ~p_out[1] || n_vs !== ~p_out[0] || n_de !== p_out[2] ||
        n_de_d !== p_s2[2] || n_hs_d !== ~p_s2[1] || n_vs_d !== ~p_s2[0])
      n_errs++;
  endtask

  initial begin
    int   last_fs;
    logic vs_seen;
    rst_n = 1'b0; rst_s_n = 1'b0; en = 1'b1; en_s = 1'b1;
    #12;

    // Reset state
    check("m_rst_x", m_x, 0);           check("m_rst_de", m_de, 0);
    check("m_rst_hs", m_hs, 0);         check("m_rst_vs", m_vs, 0);
    check("m_rst_fs", m_fs, 0);         check("m_rst_fc", m_fc, 0);
    check("m_rst_de_d", m_de_d, 0);     check("m_rst_hs_d", m_hs_d, 0);
    check("n_rst_hs", n_hs, 1);         check("n_rst_vs", n_vs, 1);
    check("n_rst_hs_d", n_hs_d, 1);     check("n_rst_de_d", n_de_d, 0);

    // ---- small builds: two full frames ----
    rst_s_n = 1'b1;
    step(1);
    check("s_first_x", s_x, 0);  check("s_first_y", s_y, 0);
    check("s_first_de", s_de, 1); check("s_first_fs", s_fs, 1);
    check("s_first_fc", s_fc, 0);
    ex = 0; ey = 0; frames = 0; s_errs = 0; n_errs = 0;
    p_out = 3'b100; p_s1 = 3'b000; p_s2 = 3'b000;
    last_fs = 0; vs_seen = 1'b0;
    for (int t = 1; t <= 240; t++) begin
      s_model_step();
      if (s_fs) begin
        check("s_fs_period", t - last_fs, 120);
        check("s_fc_at_fs", s_fc, frames);
        last_fs = t;
      end
      if (s_vs && !vs_seen) begin
        vs_seen = 1'b1;
        check("s_vs_rise_x", s_x, 0);
        check("s_vs_rise_y", s_y, 5);
      end
    end
    check("s_raster", s_errs, 0);
    check("n_pol0_delay", n_errs, 0);
    check("s_fc_two", s_fc, 2);

    // Enable gap at (0,0): frame_start drops and does not repeat
    en_s = 1'b0;
    step(100);
    check("s_gap_x", s_x, 0);  check("s_gap_y", s_y, 0);
    check("s_gap_fs", s_fs, 0); check("s_gap_fc", s_fc, 2);
    check("n_gap_de_d", n_de_d, 0);
    en_s = 1'b1;
    s_model_step();
    check("s_resume_x", s_x, 1); check("s_resume_fs", s_fs, 0);
    check("n_resume_de_d", n_de_d, 0);
    s_model_step();
    check("n_gap_de_d_lag", n_de_d, 1);

    // Reset while the active-low hsync is asserted
    repeat (9) s_model_step();
    check("n_hs_active", n_hs, 0);
    check("s_pre_rst_errs", s_errs, 0);
    rst_s_n = 1'b0;
    #1;
    check("n_mid_rst_hs", n_hs, 1);   check("n_mid_rst_vs", n_vs, 1);
    check("n_mid_rst_hs_d", n_hs_d, 1); check("n_mid_rst_de_d", n_de_d, 0);
    check("s_mid_rst_x", s_x, 0);     check("s_mid_rst_fc", s_fc, 0);
    check("s_mid_rst_de", s_de, 0);
    rst_s_n = 1'b1;
    step(1);
    check("s_restart_x", s_x, 0);  check("s_restart_y", s_y, 0);
    check("s_restart_fs", s_fs, 1); check("s_restart_fc", s_fc, 0);

    // ---- 720p build: line timing ----
    rst_n = 1'b1;
    step(1);
    check("m_first_x", m_x, 0);  check("m_first_y", m_y, 0);
    check("m_first_de", m_de, 1); check("m_first_fs", m_fs, 1);
    check("m_first_fc", m_fc, 0); check("m_first_hs", m_hs, 0);
    step(1279);
    check("m_x1279", m_x, 1279); check("m_de1279", m_de, 1); check("m_fs_off", m_fs, 0);
    step(1);
    check("m_x1280", m_x, 1280); check("m_de1280", m_de, 0); check("m_de_d1280", m_de_d, 1);
    step(1);
    check("m_de_d1281", m_de_d, 1);
    step(1);
    check("m_de_d1282", m_de_d, 0);
    step(107);
    check("m_x1389", m_x, 1389); check("m_hs1389", m_hs, 0);
    step(1);
    check("m_hs1390", m_hs, 1); check("m_hs_d1390", m_hs_d, 0);
    step(39);
    check("m_x1429", m_x, 1429); check("m_hs1429", m_hs, 1);
    step(1);
    check("m_hs1430", m_hs, 0); check("m_hs_d1430", m_hs_d, 1);
    step(219);
    check("m_x1649", m_x, 1649); check("m_y_line0", m_y, 0);
    step(1);
    check("m_wrap_x", m_x, 0); check("m_wrap_y", m_y, 1);
    check("m_wrap_de", m_de, 1); check("m_wrap_de_d", m_de_d, 0);
    check("m_wrap_fs", m_fs, 0); check("m_wrap_vs", m_vs, 0);
    step(2);
    check("m_wrap_de_d2", m_de_d, 1);

    // Enable gap at x=500
    step(498);
    check("m_x500", m_x, 500);
    en = 1'b0;
    step(100);
    check("m_hold_x", m_x, 500); check("m_hold_y", m_y, 1);
    check("m_hold_de", m_de, 1); check("m_hold_fs", m_fs, 0);
    en = 1'b1;
    step(1);
    check("m_resume_x", m_x, 501);

    // Enable gap at the active/blank edge: the delay line holds with it
    step(779);
    check("m_x1280_l1", m_x, 1280); check("m_de_d_pregap", m_de_d, 1);
    en = 1'b0;
    step(100);
    check("m_de_d_hold", m_de_d, 1); check("m_hold_x2", m_x, 1280);
    en = 1'b1;
    step(1);
    check("m_de_d_after_gap", m_de_d, 1);
    step(1);
    check("m_de_d_after_gap2", m_de_d, 0);

    // Mid-line reset while hsync is active
    step(118);
    check("m_x1400", m_x, 1400); check("m_hs1400", m_hs, 1);
    rst_n = 1'b0;
    #1;
    check("m_mid_rst_x", m_x, 0);   check("m_mid_rst_y", m_y, 0);
    check("m_mid_rst_hs", m_hs, 0); check("m_mid_rst_hs_d", m_hs_d, 0);
    check("m_mid_rst_de", m_de, 0); check("m_mid_rst_fs", m_fs, 0);
    rst_n = 1'b1;
    step(1);
    check("m_restart_x", m_x, 0);  check("m_restart_y", m_y, 0);
    check("m_restart_fs", m_fs, 1); check("m_restart_fc", m_fc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator for the 1280x720 display path; it produces the pixel coordinates and syncs that the sprite, background and text renderers consume. It drives `i_x`, `i_y` and `i_v_sync` for every sprite module, and the registered de/sync pair used by the HDMI encoder. A delay line realigns de/syncs with the pixel-colour pipeline downstream of the renderers.

## Interface
- `H_ACTIVE`, 1280, active pixels per line
- `H_FP`, 110, horizontal front porch (clocks)
- `H_SYNC`, 40, hsync width
- `H_BP`, 220, horizontal back porch
- `V_ACTIVE`, 720, active lines
- `V_FP`, 5, vertical front porch (lines)
- `V_SYNC`, 5, vsync width
- `V_BP`, 20, vertical back porch
- `SYNC_POL`, 1'b1, sync active level (1 = positive)
- `PIPE_DELAY`, 2, extra stages on the delayed de/sync outputs (0..8)

Ports:
- `i_clk`  in  1  pixel clock, 74.25 MHz
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_enable`  in  1  raster advances only while high
- `o_x`  out  16  horizontal position 0..H_TOTAL-1
- `o_y`  out  16  vertical position 0..V_TOTAL-1
- `o_de`  out  1  high when `o_x<H_ACTIVE && o_y<V_ACTIVE`
- `o_h_sync`  out  1  hsync, aligned with `o_x`
- `o_v_sync`  out  1  vsync, aligned with `o_y`
- `o_frame_start`  out  1  one-clock pulse when `o_x==0 && o_y==0`
- `o_frame_count`  out  16  completed frames, wrapping
- `o_de_d`, `o_h_sync_d`, `o_v_sync_d`  out  1 each  `o_de`/syncs delayed by PIPE_DELAY clocks

## Operation
- H_TOTAL = sum of H params (1650); V_TOTAL = sum of V params (750). Internal counters h_cnt and v_cnt are 16-bit, unsigned.
- While `i_enable`=1, h_cnt increments each clock. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt wraps from V_TOTAL-1 to 0 on that same clock.
- hsync is asserted for `H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC`. It is SYNC_POL when asserted and ~SYNC_POL otherwise.
- vsync is asserted for `V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC`, over whole lines (vsync changes only when h_cnt=0).
- Output register stage: `o_x`, `o_y`, `o_de`, `o_h_sync`, `o_v_sync`, `o_frame_start` are all loaded from the same counter value, so they are always mutually coherent.
- `o_frame_count` increments on the clock where v_cnt and h_cnt both wrap. Its new value becomes visible together with `o_frame_start`. It wraps FFFF->0000.
- `i_enable`=0: counters and all output registers hold (syncs included). The delay line also holds. `o_frame_start` is forced 0 while held and does not repeat on resume.
- Delay line: PIPE_DELAY shift stages of {de, hs, vs}, fed from the output registers. With PIPE_DELAY=0, the `_d` outputs equal the undelayed ones.
- Reset (async assert, at any point mid-frame):
  - counters go to 0
  - `o_x`=0, `o_y`=0, `o_de`=0, `o_frame_start`=0, `o_frame_count`=0
  - syncs go to the inactive level ~SYNC_POL
  - delay stages: de=0, syncs inactive
- Reset release: deassertion is synchronized by the top-level reset bridge. The raster restarts at (0,0) and does not skip to the next frame.

## Timing
- Output register latency is 1 clock from the counter. On the first enabled clock after reset release: `o_x`=0, `o_y`=0, `o_de`=1, `o_frame_start`=1, `o_frame_count`=0.
- The first frame after reset is not counted until it completes. `o_frame_count` becomes 1 at the second `o_frame_start`.
- Line period is exactly H_TOTAL enabled clocks; frame period is H_TOTAL*V_TOTAL (1,237,500).
- `o_v_sync` rising edge (SYNC_POL=1) coincides with `o_x`=0, `o_y`=725. Sprite motion, which is clocked on vsync, therefore updates in vertical blanking.
- `_d` outputs lag their undelayed counterparts by exactly PIPE_DELAY enabled clocks.

## Structure
- Shared package `video_pkg`:
  - 720p timing constants (H_/V_ defaults, H_TOTAL, V_TOTAL)
  - SCREEN_W=1280 and SCREEN_H=720, also used by the sprite modules
  - the pixel coordinate width constant (16)
- One sub-module, `sync_delay_line`: a parameterized-depth shift register with enable and async reset, reused later for colour alignment.

## Test plan
- Reset release with enable high: first clock gives x=0, y=0, de=1, frame_start=1. x reaches 1279 with de=1; at x=1280, de=0. hsync is high for x=1390..1429 only.
- Run 2 full frames: frame_start pulses are exactly 1,237,500 clocks apart, and frame_count reads 1 then 2. vsync is high for y=725..729, starting at x=0.
- Drop enable for 100 clocks at x=500, y=300: all outputs frozen, then resume at x=501. Repeat the drop at x=0, y=0 and check frame_start does not re-pulse on resume.
- Assert reset at x=800, y=400: outputs immediately go to their reset values with syncs inactive. After release the raster restarts at (0,0) with frame_count=0.
- PIPE_DELAY=2: `o_de_d` equals `o_de` delayed by 2 clocks across a line boundary and an enable gap. PIPE_DELAY=0 gives `_d` == undelayed.
- SYNC_POL=0 build: syncs idle high and pulse low over the same x/y windows.
